muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-002 i_reset  in  1  asynchronous, active-high reset.
REQ-003 i_req_valid  in  1  operation request; i_req_ready  out  1  sequencer can accept.
REQ-004 i_funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 i_op1, i_op2  in  32 each  operands, sampled only on acceptance.
REQ-006 i_kill  in  1  pipeline flush; aborts any operation.
REQ-007 o_on_wait  out  1  multiply-iteration strobe to datapath; o_is_div  out  1  divide-mode strobe.
REQ-008 o_op1_signed, o_op2_signed  out  1 each  latched operand signedness; o_op2_lsb  out  1  current multiplier bit.
REQ-009 o_funct3  out  2  latched i_funct3[1:0] to datapath; o_iter  out  5  iteration index.
REQ-010 i_mul  in  64  datapath product; i_div_q, i_div_r  in  32 each  datapath quotient/remainder.
REQ-011 o_res_valid  out  1  result available; i_res_ready  in  1  consumer accepts; o_result  out  32  result.
REQ-012 o_busy  out  1  high in any state other than IDLE.

Function
REQ-013 FSM states IDLE, INIT, RUN, DONE; encoding free.
REQ-014 o_req_ready = (state==IDLE) & !i_kill; acceptance = i_req_valid & o_req_ready at a rising edge.
REQ-015 On acceptance latch funct3, op1, op2; op1_signed = funct3 in {001,010,100,110}; op2_signed = funct3 in {001,100,110}.
REQ-016 Divide-by-zero (funct3[2]=1, op2==0): IDLE->DONE directly; result DIV/DIVU 0xFFFFFFFF, REM/REMU op1.
REQ-017 Signed overflow (DIV/REM, op1=0x80000000, op2=0xFFFFFFFF): IDLE->DONE directly; result DIV 0x80000000, REM 0.
REQ-018 Otherwise IDLE->INIT; INIT lasts exactly one cycle, then RUN.
REQ-019 RUN lasts exactly 32 cycles, o_iter counting 0..31; o_iter=0 outside RUN.
REQ-020 o_on_wait = RUN & !funct3[2]; o_is_div = (INIT|RUN) & funct3[2]; both 0 in IDLE/DONE.
REQ-021 op2 shift register loaded with op2 on acceptance; o_op2_lsb = its bit 0; shifted right by 1 (MSB fill 0) at each RUN cycle edge, held in INIT.
REQ-022 At edge ending RUN cycle with o_iter=31: capture result, go DONE; MUL -> i_mul[31:0], MULH/MULHSU/MULHU -> i_mul[63:32], DIV/DIVU -> i_div_q, REM/REMU -> i_div_r.
REQ-023 Normal latency: o_res_valid asserts 34 cycles after acceptance edge; special cases (REQ-016/017): 1 cycle.
REQ-024 DONE: o_res_valid=1, o_result stable until handshake; DONE & i_res_ready -> IDLE next edge.
REQ-025 No new acceptance in DONE; first accept is earliest in the cycle after returning to IDLE.
REQ-026 i_kill in any state: next edge IDLE, o_res_valid not asserted for killed op; i_kill has priority over i_res_ready and i_req_valid.
REQ-027 o_result = 0 whenever o_res_valid=0.
REQ-028 o_op1_signed, o_op2_signed, o_funct3 hold latched values from acceptance until next acceptance.

Reset
REQ-029 i_reset asserted: state IDLE immediately, regardless of clock; any operation abandoned.
REQ-030 Reset values: o_res_valid 0, o_result 0, o_busy 0, o_on_wait 0, o_is_div 0, o_iter 0, o_op2_lsb 0, o_op1_signed 0, o_op2_signed 0, o_funct3 0.
REQ-031 o_req_ready = 0 while i_reset=1; =1 in first cycle after deassertion with i_kill=0.

Verification
REQ-032 MULHU op1=0xFFFFFFFF, op2=0xFFFFFFFF, stub i_mul=0xFFFFFFFE00000001 -> o_on_wait high 32 cycles, o_op2_lsb=1 each RUN cycle, o_res_valid at accept+34, o_result=0xFFFFFFFE.
REQ-033 MUL op2=0x00000005 -> o_op2_lsb sequence 1,0,1,0..0 over RUN iters 0..31; o_result=i_mul[31:0]; o_is_div=0 throughout.
REQ-034 DIV op1=7, op2=0 -> o_res_valid at accept+1, o_result=0xFFFFFFFF, o_is_div never high; REM op1=0x80000000, op2=0xFFFFFFFF -> o_result=0.
REQ-035 DIVU accepted, i_kill at RUN iter 10 -> IDLE next edge, no o_res_valid, o_req_ready=1 following cycle; i_kill with i_req_valid in IDLE -> no acceptance.
REQ-036 Result held 5 cycles with i_res_ready=0 -> o_result stable, o_req_ready=0; i_res_ready=1 -> IDLE next edge.
REQ-037 i_reset asserted mid-RUN between clock edges -> o_busy, o_on_wait, o_res_valid drop to 0 before next edge.

Source files
------------

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Control sequencer for an iterative RV32M multiply/divide datapath.
// Revision : 1.0
// ============================================================================
module muldiv_seq (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    input  logic        i_kill,
    output logic        o_on_wait,
    output logic        o_is_div,
    output logic        o_op1_signed,
    output logic        o_op2_signed,
    output logic        o_op2_lsb,
    output logic [1:0]  o_funct3,
    output logic [4:0]  o_iter,
    input  logic [63:0] i_mul,
    input  logic [31:0] i_div_q,
    input  logic [31:0] i_div_r,
    output logic        o_res_valid,
    input  logic        i_res_ready,
    output logic [31:0] o_result,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [2:0]  r_funct3;
    logic        r_op1_signed;
    logic        r_op2_signed;
    logic [31:0] r_op2_sr;
    logic [4:0]  r_iter;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic [31:0] w_special_result;
    logic [31:0] w_final_result;

    assign o_req_ready = (r_state == S_IDLE) & ~i_kill & ~i_reset;
    assign w_accept    = i_req_valid & o_req_ready;

    // Corner cases whose result is fixed by the ISA and need no iterations
    assign w_div_zero = i_funct3[2] & (i_op2 == 32'd0);
    assign w_div_ovf  = i_funct3[2] & ~i_funct3[0]
                      & (i_op1 == 32'h8000_0000) & (i_op2 == 32'hFFFF_FFFF);

    always_comb begin
        w_special_result = 32'd0;
        if (w_div_zero)
            w_special_result = i_funct3[1] ? i_op1 : 32'hFFFF_FFFF;
        else if (w_div_ovf)
            w_special_result = i_funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    always_comb begin
        w_final_result = i_mul[63:32];
        if (r_funct3[2])
            w_final_result = r_funct3[1] ? i_div_r : i_div_q;
        else if (r_funct3[1:0] == 2'b00)
            w_final_result = i_mul[31:0];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_funct3     <= 3'd0;
            r_op1_signed <= 1'b0;
            r_op2_signed <= 1'b0;
            r_op2_sr     <= 32'd0;
            r_iter       <= 5'd0;
            r_result     <= 32'd0;
        end else if (i_kill) begin
            r_state  <= S_IDLE;
            r_iter   <= 5'd0;
            r_result <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_funct3     <= i_funct3;
                        r_op1_signed <= (i_funct3 == 3'b001) | (i_funct3 == 3'b010)
                                      | (i_funct3 == 3'b100) | (i_funct3 == 3'b110);
                        r_op2_signed <= (i_funct3 == 3'b001) | (i_funct3 == 3'b100)
                                      | (i_funct3 == 3'b110);
                        r_op2_sr     <= i_op2;
                        if (w_div_zero | w_div_ovf) begin
                            r_result <= w_special_result;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_INIT;
                        end
                    end
                end
                S_INIT: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_op2_sr <= {1'b0, r_op2_sr[31:1]};
                    if (r_iter == 5'd31) begin
                        r_iter   <= 5'd0;
                        r_result <= w_final_result;
                        r_state  <= S_DONE;
                    end else begin
                        r_iter <= r_iter + 5'd1;
                    end
                end
                S_DONE: begin
                    if (i_res_ready) begin
                        r_result <= 32'd0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_res_valid  = (r_state == S_DONE);
    assign o_result     = r_result;
    assign o_on_wait    = (r_state == S_RUN) & ~r_funct3[2];
    assign o_is_div     = ((r_state == S_INIT) | (r_state == S_RUN)) & r_funct3[2];
    assign o_iter       = r_iter;
    assign o_op2_lsb    = r_op2_sr[0];
    assign o_op1_signed = r_op1_signed;
    assign o_op2_signed = r_op2_signed;
    assign o_funct3     = r_funct3[1:0];

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Purpose  : Self-checking bench for muldiv_seq with a stub datapath.
// Revision : 1.0
// ============================================================================
module tb_muldiv_seq;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        i_kill = 1'b0;
    logic        i_res_ready = 1'b0;
    logic [2:0]  i_funct3 = 3'd0;
    logic [31:0] i_op1 = 32'd0;
    logic [31:0] i_op2 = 32'd0;
    logic [63:0] i_mul;
    logic [31:0] i_div_q;
    logic [31:0] i_div_r;
    logic        o_req_ready, o_on_wait, o_is_div, o_op1_signed, o_op2_signed;
    logic        o_op2_lsb, o_res_valid, o_busy;
    logic [1:0]  o_funct3;
    logic [4:0]  o_iter;
    logic [31:0] o_result;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    muldiv_seq dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready), .i_funct3(i_funct3), .i_op1(i_op1),
        .i_op2(i_op2), .i_kill(i_kill), .o_on_wait(o_on_wait),
        .o_is_div(o_is_div), .o_op1_signed(o_op1_signed),
        .o_op2_signed(o_op2_signed), .o_op2_lsb(o_op2_lsb),
        .o_funct3(o_funct3), .o_iter(o_iter), .i_mul(i_mul),
        .i_div_q(i_div_q), .i_div_r(i_div_r), .o_res_valid(o_res_valid),
        .i_res_ready(i_res_ready), .o_result(o_result), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural RV32M result, straight from the ISA definition
    function automatic logic [31:0] rv32m(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic signed [31:0] sa32, sb32;
        sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
        ua = {32'd0, a};       ub = {32'd0, b};
        sa32 = a;              sb32 = b;
        p = 64'd0;
        case (f)
            3'b000: begin p = ua * ub; return p[31:0];  end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa32 / sb32;
            end
            3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa32 % sb32;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Transaction-level model: what is in flight and how many cycles since acceptance
    bit          m_act = 1'b0, m_done = 1'b0, m_s1 = 1'b0, m_s2 = 1'b0;
    int          m_cnt = 0;
    logic [2:0]  m_f3 = 3'd0;
    logic [31:0] m_op1 = 32'd0, m_op2 = 32'd0, m_res = 32'd0;

    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            m_act <= 1'b0; m_done <= 1'b0; m_cnt <= 0; m_f3 <= 3'd0;
            m_s1 <= 1'b0; m_s2 <= 1'b0; m_op1 <= 32'd0; m_op2 <= 32'd0; m_res <= 32'd0;
        end else if (i_kill) begin
            m_act <= 1'b0; m_done <= 1'b0;
        end else if (m_done) begin
            if (i_res_ready) m_done <= 1'b0;
        end else if (m_act) begin
            if (m_cnt == 33) begin m_act <= 1'b0; m_done <= 1'b1; end
            m_cnt <= m_cnt + 1;
        end else if (i_req_valid) begin
            m_f3  <= i_funct3; m_op1 <= i_op1; m_op2 <= i_op2;
            m_res <= rv32m(i_funct3, i_op1, i_op2);
            m_s1  <= (i_funct3 inside {3'b001, 3'b010, 3'b100, 3'b110});
            m_s2  <= (i_funct3 inside {3'b001, 3'b100, 3'b110});
            if (is_special(i_funct3, i_op1, i_op2)) m_done <= 1'b1;
            else begin m_act <= 1'b1; m_cnt <= 1; end
        end
    end

    // Stub datapath: full product and quotient/remainder of the accepted operands
    logic [63:0] st_a, st_b;
    logic signed [31:0] st_sa, st_sb;
    always_comb begin
        st_a = {{32{m_op1[31] & (m_f3[1:0] == 2'b01 || m_f3[1:0] == 2'b10)}}, m_op1};
        st_b = {{32{m_op2[31] & (m_f3[1:0] == 2'b01)}}, m_op2};
        st_sa = m_op1; st_sb = m_op2;
        i_mul = st_a * st_b;
        i_div_q = 32'd0; i_div_r = 32'd0;
        if (m_op2 != 32'd0) begin
            if (m_f3[0]) begin
                i_div_q = m_op1 / m_op2; i_div_r = m_op1 % m_op2;
            end else if (!(m_op1 == 32'h8000_0000 && m_op2 == 32'hFFFF_FFFF)) begin
                i_div_q = st_sa / st_sb; i_div_r = st_sa % st_sb;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge i_clk) begin
        if (chk_en) begin
            bit run;
            run = m_act && (m_cnt >= 2);
            chk("busy",       o_busy,      m_act | m_done);
            chk("res_valid",  o_res_valid, m_done);
            chk("result",     o_result,    m_done ? m_res : 32'd0);
            chk("req_ready",  o_req_ready, !(m_act | m_done) && !i_kill && !i_reset);
            chk("iter",       o_iter,      run ? m_cnt - 2 : 0);
            chk("on_wait",    o_on_wait,   run && !m_f3[2]);
            chk("is_div",     o_is_div,    m_act && m_f3[2]);
            chk("op1_signed", o_op1_signed, m_s1);
            chk("op2_signed", o_op2_signed, m_s2);
            chk("funct3",     o_funct3,    m_f3[1:0]);
            if (m_act) chk("op2_lsb", o_op2_lsb, run ? m_op2[m_cnt - 2] : m_op2[0]);
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        #1;
        i_req_valid = 1'b1; i_funct3 = f3; i_op1 = a; i_op2 = b;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
    endtask

    int lat, n_wait, n_lsb1, n_div;
    logic [31:0] lsbv;

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        issue(f3, a, b);
        lat = 0; n_wait = 0; n_lsb1 = 0; n_div = 0; lsbv = 32'd0;
        while (lat < 60) begin
            @(negedge i_clk);
            lat++;
            if (o_on_wait) begin
                n_wait++; lsbv[o_iter] = o_op2_lsb;
                if (o_op2_lsb) n_lsb1++;
            end
            if (o_is_div) n_div++;
            if (o_res_valid) break;
        end
        if (!o_res_valid) chk("result timeout", 0, 1);
    endtask

    task automatic consume();
        i_res_ready = 1'b1;
        @(posedge i_clk); #1;
        i_res_ready = 1'b0;
    endtask

    typedef struct { logic [2:0] f; logic [31:0] a; logic [31:0] b; int lat; logic [31:0] r; } vec_t;
    vec_t vecs[12];

    initial begin
        vecs[0]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'h0000_0000};
        vecs[1]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFF};
        vecs[2]  = '{3'b101, 32'd7,         32'd0,         1,  32'hFFFF_FFFF};
        vecs[3]  = '{3'b110, 32'd7,         32'd0,         1,  32'd7};
        vecs[4]  = '{3'b111, 32'h8000_0000, 32'd0,         1,  32'h8000_0000};
        vecs[5]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1,  32'h8000_0000};
        vecs[6]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1,  32'd0};
        vecs[7]  = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0};
        vecs[8]  = '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000};
        vecs[9]  = '{3'b100, 32'hFFFF_FFEC, 32'd3,         34, 32'hFFFF_FFFA};
        vecs[10] = '{3'b110, 32'hFFFF_FFEC, 32'd3,         34, 32'hFFFF_FFFE};
        vecs[11] = '{3'b000, 32'd7,         32'd6,         34, 32'd42};

        // Reset state
        repeat (2) @(negedge i_clk);
        chk("rst busy", o_busy, 0);           chk("rst res_valid", o_res_valid, 0);
        chk("rst result", o_result, 0);       chk("rst on_wait", o_on_wait, 0);
        chk("rst is_div", o_is_div, 0);       chk("rst iter", o_iter, 0);
        chk("rst op2_lsb", o_op2_lsb, 0);     chk("rst op1_signed", o_op1_signed, 0);
        chk("rst op2_signed", o_op2_signed, 0); chk("rst funct3", o_funct3, 0);
        chk("rst req_ready", o_req_ready, 0);
        #2 i_reset = 1'b0;
        chk_en = 1'b1;
        @(negedge i_clk);
        chk("req_ready after reset", o_req_ready, 1);

        // MULHU all-ones
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mulhu latency", lat, 34);
        chk("mulhu on_wait cycles", n_wait, 32);
        chk("mulhu lsb ones", n_lsb1, 32);
        chk("mulhu result", o_result, 32'hFFFF_FFFE);
        consume();

        // MUL with op2=5: multiplier bit stream
        run_op(3'b000, 32'h1234_5678, 32'd5);
        chk("mul lsb sequence", lsbv, 32'h0000_0005);
        chk("mul is_div cycles", n_div, 0);
        chk("mul result", o_result, 32'h5B05_B058);
        consume();

        // Directed table: latency and literal result
        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d result", i), o_result, vecs[i].r);
            if (vecs[i].lat == 1) chk($sformatf("vec%0d is_div", i), n_div, 0);
            else if (vecs[i].f[2]) chk($sformatf("vec%0d is_div", i), n_div, 33);
            consume();
        end

        // Kill during a divide at iteration 10
        begin
            bit found, seen;
            found = 1'b0; seen = 1'b0;
            issue(3'b101, 32'd100, 32'd7);
            for (int k = 0; k < 40 && !found; k++) begin
                @(negedge i_clk);
                if (o_busy && o_iter == 5'd10) found = 1'b1;
            end
            chk("kill reached iter10", found, 1);
            #1 i_kill = 1'b1;
            @(posedge i_clk); #1;
            i_kill = 1'b0;
            chk("kill busy", o_busy, 0);
            chk("kill res_valid", o_res_valid, 0);
            @(negedge i_clk);
            chk("kill req_ready", o_req_ready, 1);
            repeat (40) begin
                @(negedge i_clk);
                if (o_res_valid) seen = 1'b1;
            end
            chk("kill no result", seen, 0);
        end

        // Kill beats a request in IDLE
        #1 i_req_valid = 1'b1; i_kill = 1'b1; i_funct3 = 3'b000;
        #1 chk("kill blocks ready", o_req_ready, 0);
        @(posedge i_clk); #1;
        i_req_valid = 1'b0; i_kill = 1'b0;
        chk("kill blocks accept", o_busy, 0);

        // Result held while consumer stalls
        run_op(3'b000, 32'd3, 32'd4);
        repeat (5) begin
            @(negedge i_clk);
            chk("hold result", o_result, 32'd12);
            chk("hold req_ready", o_req_ready, 0);
        end
        consume();
        chk("hold release", o_busy, 0);

        // Asynchronous reset mid-RUN
        begin
            bit found;
            found = 1'b0;
            issue(3'b000, 32'd9, 32'd9);
            for (int k = 0; k < 40 && !found; k++) begin
                @(negedge i_clk);
                if (o_on_wait && o_iter == 5'd5) found = 1'b1;
            end
            chk("reset reached iter5", found, 1);
            #2 i_reset = 1'b1;
            #1;
            chk("async rst busy", o_busy, 0);
            chk("async rst on_wait", o_on_wait, 0);
            chk("async rst res_valid", o_res_valid, 0);
            @(negedge i_clk);
            #2 i_reset = 1'b0;
            @(negedge i_clk);
            chk("ready after async rst", o_req_ready, 1);
        end

        run_op(3'b011, 32'h8000_0000, 32'd4);
        chk("recovery mulhu", o_result, 32'd2);
        consume();

        repeat (2) @(negedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
